// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
//               c_XLEN      - default data / PC width
//               fetch_entry_t - one buffered instruction with its PC
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int c_XLEN = 32;

  typedef struct packed {
    logic [c_XLEN-1:0] pc;
    logic [c_XLEN-1:0] insn;
  } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular FIFO of fetch_entry_t between the imem response and
//               decode. Flush empties it in one cycle and takes priority over
//               push/pop.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_flush        - discard all entries
//               i_push         - write i_push_data at tail
//               i_push_data    - entry to write
//               i_pop          - advance head (ignored when empty)
//               o_count        - number of valid entries
//               o_head         - entry at head (undefined when empty)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  fetch_entry_t  i_push_data,
  input  logic          i_pop,
  output logic [CW-1:0] o_count,
  output fetch_entry_t  o_head
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // The fetch credit rule keeps the queue from ever being full at a push;
  // the full guard only protects against misuse.
  assign w_do_push = i_push && !i_flush && (r_count != CW'(DEPTH));
  assign w_do_pop  = i_pop  && !i_flush && (r_count != '0);

  // Storage carries no reset: entries are only observed when counted valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_tail] <= i_push_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so increments wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_do_pop) begin
        r_head <= r_head + AW'(1);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the word-indexed PC, issues
//               reads to a 1-cycle-latency instruction memory, buffers the
//               returned instructions with their PCs and hands them to decode
//               over valid/ready. A redirect discards buffered and in-flight
//               instructions and restarts fetch at redirect_pc.
//               XLEN must equal fetch_pkg::c_XLEN (width of fetch_entry_t).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               imem_read_en/addr - read strobe and word address
//               imem_read_data    - instruction, one cycle after the strobe
//               fetch_valid/ready - handshake to decode
//               fetch_insn/pc     - head instruction and PC (0 when empty)
//               redirect_valid/pc - flush and restart fetch
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN        = c_XLEN,
  parameter logic [XLEN-1:0] PC_RESET    = '0,
  parameter int              QUEUE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_read_en,
  output logic [XLEN-1:0] imem_read_addr,
  input  logic [XLEN-1:0] imem_read_data,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_insn,
  output logic [XLEN-1:0] fetch_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [XLEN-1:0] r_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occupancy;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;
  logic            w_credit_ok;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;

  // Credit counts queued entries plus the outstanding read; a pop in the
  // same cycle is deliberately not credited so fetch_ready never reaches
  // imem_read_en combinationally.
  assign w_occupancy = {1'b0, w_count} + (CW+1)'(r_inflight);
  assign w_credit_ok = w_occupancy < (CW+1)'(QUEUE_DEPTH);
  assign w_issue     = !rst && (redirect_valid || w_credit_ok);

  assign imem_read_en   = w_issue;
  assign imem_read_addr = redirect_valid ? redirect_pc : r_pc;

  // A response landing in a redirect cycle belongs to the old stream.
  assign w_push      = r_inflight && !redirect_valid;
  assign w_push_data = '{pc: r_inflight_pc, insn: imem_read_data};

  assign fetch_valid = !rst && (w_count != '0);
  // A handshake in a redirect cycle is void, so the head is not consumed.
  assign w_pop       = fetch_valid && fetch_ready && !redirect_valid;

  assign fetch_insn  = fetch_valid ? w_head.insn : '0;
  assign fetch_pc    = fetch_valid ? w_head.pc   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= PC_RESET;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_pc          <= redirect_pc + XLEN'(1);
      r_inflight    <= 1'b1;
      r_inflight_pc <= redirect_pc;
    end else if (w_issue) begin
      r_pc          <= r_pc + XLEN'(1);
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_pc;
    end else begin
      r_inflight    <= 1'b0;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head      (w_head)
  );

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit. Stimulus pushes the expected
//               PC stream (consecutive words from the restart point) whenever
//               it resets or redirects; monitors pop and compare on every
//               completed transfer. A second instance checks PC wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_read_en;
  logic [31:0] imem_read_addr;
  logic [31:0] imem_read_data;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [31:0] fetch_insn;
  logic [31:0] fetch_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        w_imem_read_en;
  logic [31:0] w_imem_read_addr;
  logic [31:0] w_imem_read_data;
  logic        w_fetch_valid;
  logic        w_fetch_ready = 1'b1;
  logic [31:0] w_fetch_insn;
  logic [31:0] w_fetch_pc;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = '0;

  int          n_cmp  = 0;
  int          n_bad  = 0;
  int          n_xfer = 0;
  int          w_idx  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .PC_RESET(32'h0), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_read_en(imem_read_en), .imem_read_addr(imem_read_addr),
    .imem_read_data(imem_read_data),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_insn(fetch_insn), .fetch_pc(fetch_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.XLEN(32), .PC_RESET(32'hFFFF_FFFE), .QUEUE_DEPTH(4)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_read_en(w_imem_read_en), .imem_read_addr(w_imem_read_addr),
    .imem_read_data(w_imem_read_data),
    .fetch_valid(w_fetch_valid), .fetch_ready(w_fetch_ready),
    .fetch_insn(w_fetch_insn), .fetch_pc(w_fetch_pc),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  // Instruction memories: fixed one-cycle read latency.
  always @(posedge clk) begin
    imem_read_data   <= imem_read_en   ? mem_word(imem_read_addr)   : 32'hDEAD_BEEF;
    w_imem_read_data <= w_imem_read_en ? mem_word(w_imem_read_addr) : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: after a restart at 'start', decode sees start, start+1, ...
  task automatic refill(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 1000; i++) exp_q.push_back(start + 32'(i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    refill(32'h0);
  endtask

  // Main monitor: every completed transfer is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (fetch_valid && fetch_ready && !redirect_valid) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_empty: got pc 0x%08h expected no transfer", fetch_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("xfer_pc", fetch_pc, mon_e);
          check("xfer_insn", fetch_insn, mem_word(mon_e));
        end
      end else if (!fetch_valid) begin
        check("empty_gate", fetch_pc | fetch_insn, 32'h0);
      end
    end
  end

  // Wrap monitor: ready is always high, so the stream restarts at the reset PC.
  always @(negedge clk) begin
    if (rst) begin
      w_idx = 0;
    end else if (w_fetch_valid) begin
      check("wrap_pc", w_fetch_pc, 32'hFFFF_FFFE + 32'(w_idx));
      check("wrap_insn", w_fetch_insn, mem_word(32'hFFFF_FFFE + 32'(w_idx)));
      w_idx++;
    end
  end

  initial begin
    int nreads;
    int r;

    // Reset state and fill latency with ready held high.
    fetch_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("rst_rd_en", 32'(imem_read_en), 32'd0);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_pc", fetch_pc, 32'h0);
    check("rst_insn", fetch_insn, 32'h0);
    tick();
    rst = 1'b0;
    refill(32'h0);
    @(negedge clk);
    check("t0_rd_en", 32'(imem_read_en), 32'd1);
    check("t0_addr", imem_read_addr, 32'h0);
    check("t0_valid", 32'(fetch_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t1_valid", 32'(fetch_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t2_valid", 32'(fetch_valid), 32'd1);
    check("t2_pc", fetch_pc, 32'h0);
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      check("stream_valid", 32'(fetch_valid), 32'd1);
    end

    // Back-pressure: exactly QUEUE_DEPTH reads, then in-order drain.
    tick();
    fetch_ready = 1'b0;
    pulse_reset();
    nreads = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_read_en) begin
        check("fill_addr", imem_read_addr, 32'(nreads));
        nreads++;
      end
      tick();
    end
    check("fill_reads", 32'(nreads), 32'd4);
    check("fill_valid", 32'(fetch_valid), 32'd1);
    fetch_ready = 1'b1;
    repeat (8) tick();

    // Redirect with three entries queued and one read in flight.
    fetch_ready = 1'b0;
    pulse_reset();
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    fetch_ready    = 1'b1;
    refill(32'h40);
    @(negedge clk);
    check("redir_rd_en", 32'(imem_read_en), 32'd1);
    check("redir_addr", imem_read_addr, 32'h40);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_r1_valid", 32'(fetch_valid), 32'd0);
    tick();
    @(negedge clk);
    check("redir_r2_valid", 32'(fetch_valid), 32'd1);
    check("redir_r2_pc", fetch_pc, 32'h40);
    repeat (6) tick();

    // Back-to-back redirects: only the last stream survives.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    refill(32'h10);
    tick();
    redirect_pc    = 32'h20;
    refill(32'h20);
    @(negedge clk);
    check("b2b_addr", imem_read_addr, 32'h20);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("b2b_r1_valid", 32'(fetch_valid), 32'd0);
    tick();
    @(negedge clk);
    check("b2b_r2_pc", fetch_pc, 32'h20);
    repeat (6) tick();

    // Reset mid-stream with a full queue.
    fetch_ready = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    check("full_valid", 32'(fetch_valid), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(fetch_valid), 32'd0);
    check("midrst_rd_en", 32'(imem_read_en), 32'd0);
    tick();
    rst = 1'b0;
    fetch_ready = 1'b1;
    refill(32'h0);
    @(negedge clk);
    check("post_rst_valid", 32'(fetch_valid), 32'd0);
    check("post_rst_addr", imem_read_addr, 32'h0);
    check("post_rst_rd_en", 32'(imem_read_en), 32'd1);
    repeat (6) tick();

    // Randomized traffic: ready jitter, redirects (some near wrap), resets.
    for (int i = 0; i < 600; i++) begin
      tick();
      r = int'($urandom_range(0, 99));
      redirect_valid = 1'b0;
      if (rst) begin
        rst = 1'b0;
        refill(32'h0);
      end else if (r < 2) begin
        rst = 1'b1;
      end
      if (!rst && r >= 2 && r < 8) begin
        redirect_valid = 1'b1;
        redirect_pc    = (r < 4) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
        refill(redirect_pc);
      end
      fetch_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    if (rst) begin
      rst = 1'b0;
      refill(32'h0);
    end
    redirect_valid = 1'b0;
    fetch_ready    = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check("drain_valid", 32'(fetch_valid), 32'd1);
    check("xfer_progress", 32'(n_xfer > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
